// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller. Holds a frame-coherent copy of
// the displayed value, walks the digits with a blanking gap between them, and
// drives the shared BCD converter plus active-low anode / decimal-point pins.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          lz_en,
    input  logic [4*NUM_DIGITS-1:0]       value_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          load,
    output logic                          load_ack,
    output logic [3:0]                    bcd,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                    state, state_d;
    logic [IDX_W-1:0]          idx, idx_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic                      boundary;

    logic [4*NUM_DIGITS-1:0]   active_val, active_val_d;
    logic [NUM_DIGITS-1:0]     active_dp, active_dp_d;
    logic [4*NUM_DIGITS-1:0]   shadow_val;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic                      pending, pending_d;
    logic                      ack_d;

    logic [NUM_DIGITS-1:0]     sup;
    logic                      all_zero;
    logic [NUM_DIGITS-1:0]     an_d;
    logic                      dp_n_d;
    logic [3:0]                bcd_d;

    // Scan sequencing: dead-time, drive window, digit stepping, frame boundary.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d  = state;
        idx_d    = idx;
        cnt_d    = cnt;
        boundary = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_d = S_BLANK;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    if (cnt == BLANK_END) begin
                        state_d = S_DRIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt == DIV_END) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        if (idx == LAST_IDX) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Load handshake: promote shadow (or a same-cycle load) at the boundary or while idle.
    always_comb begin
        active_val_d = active_val;
        active_dp_d  = active_dp;
        pending_d    = pending;
        ack_d        = 1'b0;
        if (boundary) begin
            if (load) begin
                active_val_d = value_in;
                active_dp_d  = dp_in;
            end else if (pending) begin
                active_val_d = shadow_val;
                active_dp_d  = shadow_dp;
            end
            ack_d     = load | pending;
            pending_d = 1'b0;
        end else begin
            if (state == S_IDLE && pending) begin
                active_val_d = shadow_val;
                active_dp_d  = shadow_dp;
                ack_d        = 1'b1;
                pending_d    = 1'b0;
            end
            if (load) begin
                pending_d = 1'b1;
            end
        end
    end

    // Leading-zero mask: a digit is dark if it and everything above it is zero (digit 0 never).
    always_comb begin
        all_zero = 1'b1;
        sup      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (active_val_d[4*k +: 4] == 4'd0);
            sup[k]   = lz_en & all_zero & (k != 0);
        end
    end

    // Next values of the pin outputs, derived from the next state so the pins are registered.
    always_comb begin
        an_d   = '1;
        dp_n_d = 1'b1;
        bcd_d  = bcd;
        if (state_d == S_DRIVE && !sup[idx_d]) begin
            an_d[idx_d] = 1'b0;
            dp_n_d      = ~active_dp_d[idx_d];
        end
        // Nibble only moves on BLANK entry so it is steady across the whole drive window.
        if (state_d == S_BLANK && state != S_BLANK) begin
            bcd_d = active_val_d[4*idx_d +: 4];
        end
    end

    // State, value and output registers; everything returns to reset values asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            active_val <= '0;
            active_dp  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            an         <= '1;
            dp_n       <= 1'b1;
            bcd        <= 4'd0;
            load_ack   <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            active_val <= active_val_d;
            active_dp  <= active_dp_d;
            pending    <= pending_d;
            if (load) begin
                shadow_val <= value_in;
                shadow_dp  <= dp_in;
            end
            an         <= an_d;
            dp_n       <= dp_n_d;
            bcd        <= bcd_d;
            load_ack   <= ack_d;
            frame_tick <= boundary;
        end
    end

    assign digit_idx = idx;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with NUM_DIGITS=4, DIV=4, BLANK_CYC=2
// (digit slot = 6 cycles, frame = 24 cycles). Outputs sampled on falling edges.
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int DIVP  = 4;
    localparam int BLANK = 2;
    localparam int SLOT  = BLANK + DIVP;
    localparam int FRAME = N * SLOT;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic         lz_en;
    logic [15:0]  value_in;
    logic [3:0]   dp_in;
    logic         load;
    logic         load_ack;
    logic [3:0]   bcd;
    logic [3:0]   an;
    logic         dp_n;
    logic [1:0]   digit_idx;
    logic         frame_tick;

    int tests  = 0;
    int failed = 0;

    seg7_scan_ctrl #(.NUM_DIGITS(N), .DIV(DIVP), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lz_en      (lz_en),
        .value_in   (value_in),
        .dp_in      (dp_in),
        .load       (load),
        .load_ack   (load_ack),
        .bcd        (bcd),
        .an         (an),
        .dp_n       (dp_n),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Checks one full frame cycle by cycle, starting on the first blank cycle of digit 0.
    // Up to two loads can be issued at given frame positions (-1 = none).
    task automatic run_frame(input string name, input logic [15:0] val, input logic [3:0] dp,
                             input logic [3:0] sup, input bit tick, input bit ack,
                             input int lp1, input logic [15:0] lv1, input logic [3:0] ld1,
                             input int lp2, input logic [15:0] lv2, input logic [3:0] ld2);
        for (int p = 0; p < FRAME; p++) begin
            int d;
            bit blank;
            logic [3:0] an_exp;
            logic       dp_exp;
            logic [3:0] bcd_exp;
            logic       tick_exp;
            logic       ack_exp;
            @(negedge clk);
            load     = 1'b0;
            d        = p / SLOT;
            blank    = (p % SLOT) < BLANK;
            an_exp   = 4'hF;
            dp_exp   = 1'b1;
            if (!blank && !sup[d]) begin
                an_exp[d] = 1'b0;
                dp_exp    = ~dp[d];
            end
            bcd_exp  = val[4*d +: 4];
            tick_exp = (p == 0) && tick;
            ack_exp  = (p == 0) && ack;
            tests++;
            if (an !== an_exp || dp_n !== dp_exp || bcd !== bcd_exp ||
                digit_idx !== 2'(d) || frame_tick !== tick_exp || load_ack !== ack_exp) begin
                failed++;
                $display("FAIL %s p=%0d: an=%b want %b, dp_n=%b want %b, bcd=%h want %h, idx=%0d want %0d, tick=%b want %b, ack=%b want %b",
                         name, p, an, an_exp, dp_n, dp_exp, bcd, bcd_exp, digit_idx, d,
                         frame_tick, tick_exp, load_ack, ack_exp);
            end
            if (p == lp1) begin
                load = 1'b1; value_in = lv1; dp_in = ld1;
            end
            if (p == lp2) begin
                load = 1'b1; value_in = lv2; dp_in = ld2;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; enable = 1'b0; lz_en = 1'b0; load = 1'b0;
        value_in = 16'h0; dp_in = 4'h0;
        #12;
        tests++;
        if (an !== 4'hF || dp_n !== 1'b1 || bcd !== 4'h0 || digit_idx !== 2'd0 ||
            load_ack !== 1'b0 || frame_tick !== 1'b0) begin
            failed++;
            $display("FAIL reset_values: an=%b dp_n=%b bcd=%h idx=%0d ack=%b tick=%b, want 1111 1 0 0 0 0",
                     an, dp_n, bcd, digit_idx, load_ack, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (an !== 4'hF || dp_n !== 1'b1 || bcd !== 4'h0 || frame_tick !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL idle_dark: %0d bad cycles out of 100, want 0", bad);
        end
    endtask

    task automatic test_scan_order();
        // Load while idle: applied the cycle after capture with one ack.
        @(negedge clk);
        value_in = 16'h4321; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        tests++;
        if (load_ack !== 1'b1) begin
            failed++;
            $display("FAIL idle_load_ack: load_ack=%b want 1", load_ack);
        end
        @(negedge clk);
        tests++;
        if (load_ack !== 1'b0) begin
            failed++;
            $display("FAIL idle_load_ack_single: load_ack=%b want 0", load_ack);
        end
        enable = 1'b1;
        run_frame("scan_first", 16'h4321, 4'b0000, 4'b0000, 1'b0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        run_frame("scan_second", 16'h4321, 4'b0000, 4'b0000, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    endtask

    task automatic test_frame_coherence();
        run_frame("coh_old", 16'h4321, 4'b0000, 4'b0000, 1'b1, 1'b0, 10, 16'h1234, 4'b0000, -1, 16'h0, 4'h0);
        run_frame("coh_new", 16'h1234, 4'b0000, 4'b0000, 1'b1, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_loads", 16'h1234, 4'b0000, 4'b0000, 1'b1, 1'b0, 3, 16'hAAAA, 4'b1111, 15, 16'hBBBB, 4'b0000);
        run_frame("b2b_last_wins", 16'hBBBB, 4'b0000, 4'b0000, 1'b1, 1'b1, 23, 16'h5555, 4'b0101, -1, 16'h0, 4'h0);
        run_frame("b2b_bypass", 16'h5555, 4'b0101, 4'b0000, 1'b1, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    endtask

    task automatic test_leading_zeros();
        lz_en = 1'b1;
        run_frame("lz_pre", 16'h5555, 4'b0101, 4'b0000, 1'b1, 1'b0, 5, 16'h0050, 4'b1000, -1, 16'h0, 4'h0);
        run_frame("lz_0050", 16'h0050, 4'b1000, 4'b1100, 1'b1, 1'b1, 7, 16'h0000, 4'b0000, -1, 16'h0, 4'h0);
        run_frame("lz_0000", 16'h0000, 4'b0000, 4'b1110, 1'b1, 1'b1, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        lz_en = 1'b0;
    endtask

    task automatic test_enable_drop();
        int bad;
        run_frame("drop_pre", 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
        repeat (10) @(negedge clk);
        tests++;
        if (an !== 4'b1101) begin
            failed++;
            $display("FAIL drop_mid_drive: an=%b want 1101", an);
        end
        enable = 1'b0;
        @(negedge clk);
        tests++;
        if (an !== 4'hF || digit_idx !== 2'd0 || dp_n !== 1'b1) begin
            failed++;
            $display("FAIL drop_next_edge: an=%b idx=%0d dp_n=%b, want 1111 0 1", an, digit_idx, dp_n);
        end
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (an !== 4'hF || frame_tick !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            failed++;
            $display("FAIL drop_idle_dark: %0d bad cycles, want 0", bad);
        end
        enable = 1'b1;
        run_frame("reenable", 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    endtask

    task automatic test_reset_mid_frame();
        run_frame("rst_pre", 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 4, 16'h9876, 4'b0010, -1, 16'h0, 4'h0);
        repeat (15) @(negedge clk);
        tests++;
        if (bcd !== 4'h8 || an !== 4'b1011) begin
            failed++;
            $display("FAIL rst_before: bcd=%h an=%b, want 8 1011", bcd, an);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (an !== 4'hF || dp_n !== 1'b1 || bcd !== 4'h0 || digit_idx !== 2'd0 ||
            load_ack !== 1'b0 || frame_tick !== 1'b0) begin
            failed++;
            $display("FAIL rst_async: an=%b dp_n=%b bcd=%h idx=%0d ack=%b tick=%b, want 1111 1 0 0 0 0",
                     an, dp_n, bcd, digit_idx, load_ack, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("rst_after", 16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b0, -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_frame_coherence();
        test_back_to_back();
        test_leading_zeros();
        test_enable_drop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller that shares one BCD-to-7-segment converter among `NUM_DIGITS` common-anode digits. It holds a frame-coherent copy of the displayed value, steps a digit index, presents that digit's nibble on `bcd` and drives the active-low anode and decimal-point lines. It inserts a blanking dead-time between digits to suppress ghosting and optionally suppresses leading zeros. It sits between the value producer (counter, ALU, register file) and the shared converter/display pins.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits (2..8).
- `DIV`, 50000: clock cycles each digit is driven (≥2).
- `BLANK_CYC`, 16: dead-time cycles with all anodes off before each digit (≥1).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: 1 = scan; 0 = display dark (IDLE).
- `lz_en` in 1: 1 = suppress leading zeros.
- `value_in` in 4*NUM_DIGITS: digit nibbles; nibble k = bits [4k+3:4k]; digit 0 is least significant.
- `dp_in` in NUM_DIGITS: decimal points to load, 1 = lit.
- `load` in 1: one-cycle request to capture `value_in`/`dp_in`.
- `load_ack` out 1: one-cycle pulse when the captured value becomes the displayed value.
- `bcd` out 4: nibble to the shared converter.
- `an` out NUM_DIGITS: anode enables, active-low (0 = digit on).
- `dp_n` out 1: decimal point, active-low.
- `digit_idx` out clog2(NUM_DIGITS): digit currently scanned.
- `frame_tick` out 1: one-cycle pulse at the end of each full frame.

## Operation
- Registers: `active` (displayed value + dp), `shadow` (pending value + dp), `pending` flag, `idx`, cycle counter `cnt`, state.
- States: IDLE, BLANK, DRIVE.
- IDLE: `an` all 1, `dp_n`=1, `idx`=0. `enable`=1 moves to BLANK.
- BLANK: `an` all 1, `dp_n`=1, `bcd` = nibble `idx` of `active`. After BLANK_CYC cycles, moves to DRIVE.
- DRIVE: `an[idx]`=0 unless digit `idx` is suppressed; `dp_n` = ~dp[`idx`]. After DIV cycles, moves to BLANK with `idx`+1. After `idx`=NUM_DIGITS-1 it wraps to 0: that last DRIVE cycle is the frame boundary.
- Leading-zero suppression (`lz_en`=1): digit k is suppressed if it and all higher digits are 0 and k≠0. Digit 0 is never suppressed. A suppressed digit keeps its slot timing, but its anode stays 1 and `dp_n` stays 1 (its dp is ignored).
- Load handshake:
  - `load`=1 copies `value_in`/`dp_in` into `shadow` and sets `pending`. A later load before the boundary overwrites `shadow`; the last load wins.
  - At the frame boundary, if `load`=1 in that cycle, `value_in` goes directly to `active`; else if `pending`, `shadow` goes to `active`. Either case clears `pending` and pulses `load_ack` the next cycle.
  - In IDLE, a pending value is applied on the cycle after it is captured, with the same ack.
- `enable`=0 in any state: next state IDLE, `an` all 1 on the next edge, `idx`=0, `cnt`=0. `active` and `pending` are kept.
- `frame_tick` pulses on the cycle after each boundary. It does not pulse in IDLE.

## Timing
- All outputs are registered.
- Reset values: `an` all 1, `dp_n`=1, `bcd`=0, `digit_idx`=0, `load_ack`=0, `frame_tick`=0, `active`=0, `shadow`=0, `pending`=0, state IDLE.
- Digit period = BLANK_CYC+DIV cycles. Frame = NUM_DIGITS·(BLANK_CYC+DIV) cycles.
- Enable-to-first-anode latency: `enable` sampled 1 at edge t gives BLANK at t+1 and `an[0]`=0 at t+1+BLANK_CYC.
- `bcd` and `digit_idx` change only on BLANK entry, so they are stable for the whole DRIVE window.
- Exactly one anode is low at a time. No anode is low during BLANK or IDLE.
- `active` changes only at a frame boundary or in IDLE, so there is no tearing within a frame.
- Reset asserted mid-frame: all outputs return to reset values immediately, asynchronously.

## Test plan
- Reset/idle: NUM_DIGITS=4, DIV=4, BLANK_CYC=2, `enable`=0 → `an`=4'b1111, `dp_n`=1, `bcd`=0, no `frame_tick` for 100 cycles.
- Scan order: load 16'h4321, `enable`=1 → `an` repeats 1110,1101,1011,0111. Each is low 4 cycles, separated by 2 cycles of 1111. `bcd` reads 1,2,3,4. `frame_tick` period is 24 cycles.
- Frame coherence: load 16'h1234 mid-frame → display finishes with the old value. `load_ack` pulses exactly once, the cycle after the boundary. The next frame shows 4,3,2,1.
- Last load wins and boundary bypass: loads of 16'hAAAA then 16'hBBBB in one frame → only 16'hBBBB is shown, one ack. A load of 16'h5555 in the boundary cycle → shown from the next frame.
- Leading zeros: `lz_en`=1, value 16'h0050, `dp_in`=4'b1000 → `an[3]` and `an[2]` never low, `dp_n` stays 1, digits 1 and 0 still driven. Value 16'h0000 → only digit 0 lit.
- Enable drop/reset mid-DRIVE: `enable`=0 → `an`=1111 on the next edge, `idx`=0. Re-enable restarts at digit 0 after 2 blank cycles. `rst_n`=0 mid-frame → immediate reset values.
